display_ram_arbiter: RTL and testbench

//  Shares the single-port 80-column text RAM between the VGA scan reader and the RP2 CPU bus.

---
 rtl/display_ram_arbiter.sv | 144 ++++++++++++++
 tb/tb_display_ram_arbiter.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/display_ram_arbiter.sv
// Display RAM arbiter: shares the single-port text RAM between the VGA scan
// reader (every phase-0 cycle while the frame is active) and the CPU bus.
// Also produces the registered scan character and the cursor flag.
module display_ram_arbiter #(
  parameter int DEPTH        = 4000,
  parameter int COLS         = 80,
  parameter int BLINK_FRAMES = 16
) (
  input  logic        Clock,
  input  logic        Reset,
  output logic        PixelEn,
  input  logic        ScanActive,
  input  logic [11:0] ScanAddr,
  input  logic        FrameStart,
  output logic [7:0]  ScanChar,
  output logic        CursorEnable,
  input  logic [6:0]  CursorX,
  input  logic [5:0]  CursorY,
  input  logic [1:0]  CursorMode,
  input  logic        CpuReq,
  input  logic        CpuWe,
  input  logic [11:0] CpuAddr,
  input  logic [7:0]  CpuWData,
  output logic [7:0]  CpuRData,
  output logic        CpuAck,
  output logic [11:0] RamAddr,
  output logic        RamWe,
  output logic [7:0]  RamWData,
  input  logic [7:0]  RamRData
);

  localparam int          BW       = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [12:0] DepthLim = 13'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_ACK
  } cpuState_t;

  cpuState_t       state;
  logic            phase;
  logic            scanSlot;
  logic            grant;
  logic            inRange;
  logic            reqWe;
  logic            reqOk;
  logic            scanIssueD;
  logic            hitIssue;
  logic            hitD;
  logic            modeOk;
  logic            blinkVis;
  logic [BW-1:0]   blinkCnt;
  logic [12:0]     curAddr;

  // Slot decode, grant and RAM port muxing
  always_comb begin
    PixelEn  = ~phase;
    scanSlot = ~phase & ScanActive;
    inRange  = {1'b0, CpuAddr} < DepthLim;
    grant    = (state == S_IDLE) && CpuReq && !scanSlot;
    RamAddr  = grant ? CpuAddr : ScanAddr;
    RamWe    = grant && CpuWe && inRange && !Reset;
    RamWData = CpuWData;
  end

  // Cursor address match at scan issue and mode/blink qualification
  always_comb begin
    curAddr  = 13'(CursorY) * 13'(COLS) + 13'(CursorX);
    hitIssue = scanSlot && ({1'b0, ScanAddr} == curAddr);
    modeOk   = (CursorMode == 2'd1) || ((CursorMode == 2'd2) && blinkVis);
  end

  // Phase toggle and scan read pipeline (issue -> RAM data -> ScanChar)
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      phase        <= 1'b0;
      scanIssueD   <= 1'b0;
      hitD         <= 1'b0;
      ScanChar     <= '0;
      CursorEnable <= 1'b0;
    end else begin
      phase      <= ~phase;
      scanIssueD <= scanSlot;
      hitD       <= hitIssue;
      if (scanIssueD) begin
        ScanChar     <= RamRData;
        CursorEnable <= hitD && modeOk;
      end
    end
  end

  // Blink counter: toggles visibility every BLINK_FRAMES frame starts
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      blinkCnt <= '0;
      blinkVis <= 1'b1;
    end else if (FrameStart) begin
      if (blinkCnt == BW'(BLINK_FRAMES - 1)) begin
        blinkCnt <= '0;
        blinkVis <= ~blinkVis;
      end else begin
        blinkCnt <= blinkCnt + 1'b1;
      end
    end
  end

  // CPU access FSM with registered read data and acknowledge
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state    <= S_IDLE;
      reqWe    <= 1'b0;
      reqOk    <= 1'b0;
      CpuRData <= '0;
      CpuAck   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          CpuAck <= 1'b0;
          if (grant) begin
            reqWe <= CpuWe;
            reqOk <= inRange;
            state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (!reqWe)
            CpuRData <= reqOk ? RamRData : '0;
          CpuAck <= 1'b1;
          state  <= S_ACK;
        end
        S_ACK: begin
          CpuAck <= 1'b0;
          state  <= S_IDLE;
        end
        default: begin
          CpuAck <= 1'b0;
          state  <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_display_ram_arbiter.sv
// Directed bench for display_ram_arbiter with a synchronous RAM model.
module tb_display_ram_arbiter;

  logic        Clock;
  logic        Reset;
  logic        PixelEn;
  logic        ScanActive;
  logic [11:0] ScanAddr;
  logic        FrameStart;
  logic [7:0]  ScanChar;
  logic        CursorEnable;
  logic [6:0]  CursorX;
  logic [5:0]  CursorY;
  logic [1:0]  CursorMode;
  logic        CpuReq;
  logic        CpuWe;
  logic [11:0] CpuAddr;
  logic [7:0]  CpuWData;
  logic [7:0]  CpuRData;
  logic        CpuAck;
  logic [11:0] RamAddr;
  logic        RamWe;
  logic [7:0]  RamWData;
  logic [7:0]  RamRData;

  logic [7:0]  mem [0:4095];
  int          weCount = 0;
  int          weBase;
  int          errors = 0;
  int          checks = 0;

  display_ram_arbiter #(
    .DEPTH(4000),
    .COLS(80),
    .BLINK_FRAMES(2)
  ) dut (
    .Clock(Clock),
    .Reset(Reset),
    .PixelEn(PixelEn),
    .ScanActive(ScanActive),
    .ScanAddr(ScanAddr),
    .FrameStart(FrameStart),
    .ScanChar(ScanChar),
    .CursorEnable(CursorEnable),
    .CursorX(CursorX),
    .CursorY(CursorY),
    .CursorMode(CursorMode),
    .CpuReq(CpuReq),
    .CpuWe(CpuWe),
    .CpuAddr(CpuAddr),
    .CpuWData(CpuWData),
    .CpuRData(CpuRData),
    .CpuAck(CpuAck),
    .RamAddr(RamAddr),
    .RamWe(RamWe),
    .RamWData(RamWData),
    .RamRData(RamRData)
  );

  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  // Synchronous single-port RAM, read-first, one-cycle latency
  always @(posedge Clock) begin
    if (RamWe) begin
      mem[RamAddr] <= RamWData;
      weCount      <= weCount + 1;
    end
    RamRData <= mem[RamAddr];
  end

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
    mem[12'h200] = 8'h5A;
    mem[12'h201] = 8'hA5;
    mem[12'hFA0] = 8'h99;
    mem[12'd165] = 8'h3C;
    mem[12'd164] = 8'h11;

    Reset = 1'b1; ScanActive = 1'b0; ScanAddr = '0; FrameStart = 1'b0;
    CursorX = '0; CursorY = '0; CursorMode = 2'd0;
    CpuReq = 1'b1; CpuWe = 1'b1; CpuAddr = 12'h005; CpuWData = 8'hAA;

    // Reset values; a pending write must not reach the RAM
    tick(); tick(); settle();
    check("rst_pixelen", PixelEn, 1);
    check("rst_ramwe", RamWe, 0);
    check("rst_scanchar", ScanChar, 8'h00);
    check("rst_curen", CursorEnable, 0);
    check("rst_rdata", CpuRData, 8'h00);
    check("rst_ack", CpuAck, 0);
    CpuReq = 1'b0;

    // Reset asserted during WAIT of a write
    tick(); Reset = 1'b0;
    CpuReq = 1'b1; CpuWe = 1'b1; CpuAddr = 12'h010; CpuWData = 8'h55; settle();
    check("t1_grant_we", RamWe, 1);
    tick(); Reset = 1'b1; CpuReq = 1'b0; settle();
    check("t1_ack", CpuAck, 0);
    check("t1_ramwe", RamWe, 0);
    check("t1_pixelen", PixelEn, 1);
    check("t1_scanchar", ScanChar, 8'h00);
    check("t1_curen", CursorEnable, 0);
    tick(); settle();
    check("t1_ack_held", CpuAck, 0);

    // C0: phase 0 after release
    tick(); Reset = 1'b0; settle();
    check("c0_pixelen", PixelEn, 1);
    tick(); settle();                              // C1
    check("c1_pixelen", PixelEn, 0);
    check("c1_ack_none", CpuAck, 0);

    // Write 0x41 to 0x123, then read it back, scan inactive
    tick(); weBase = weCount;                      // C2
    CpuReq = 1'b1; CpuWe = 1'b1; CpuAddr = 12'h123; CpuWData = 8'h41; settle();
    check("t2_wr_we", RamWe, 1);
    check("t2_wr_addr", RamAddr, 12'h123);
    tick(); settle();                              // C3 WAIT
    check("t2_wr_ack0", CpuAck, 0);
    check("t2_wait_we", RamWe, 0);
    tick(); settle();                              // C4 ACK
    check("t2_wr_ack", CpuAck, 1);
    CpuReq = 1'b0;
    tick();                                        // C5
    CpuReq = 1'b1; CpuWe = 1'b0; settle();
    check("t2_rd_ack_low", CpuAck, 0);
    check("t2_rd_we", RamWe, 0);
    tick(); tick(); settle();                      // C7 ACK
    check("t2_rd_ack", CpuAck, 1);
    check("t2_rd_data", CpuRData, 8'h41);
    CpuReq = 1'b0;
    check("t2_we_count", weCount - weBase, 1);

    // Scan slot blocks CPU request raised in phase 0
    tick();                                        // C8 phase 0
    ScanActive = 1'b1; ScanAddr = 12'h200; CpuReq = 1'b1; CpuWe = 1'b0; CpuAddr = 12'h123; settle();
    check("t3_scan_addr", RamAddr, 12'h200);
    check("t3_scan_we", RamWe, 0);
    tick(); ScanAddr = 12'h201; settle();          // C9
    check("t3_cpu_addr", RamAddr, 12'h123);
    check("t3_ack0", CpuAck, 0);
    tick(); settle();                              // C10
    check("t3_ack1", CpuAck, 0);
    check("t3_scanchar", ScanChar, 8'h5A);
    tick(); settle();                              // C11
    check("t3_ack", CpuAck, 1);
    check("t3_rdata", CpuRData, 8'h41);
    check("t3_scanchar_hold", ScanChar, 8'h5A);
    CpuReq = 1'b0;
    tick(); settle();                              // C12
    check("t3_scanchar2", ScanChar, 8'hA5);

    // CpuReq held through ACK, scan active
    weBase = weCount;
    CpuReq = 1'b1; CpuWe = 1'b1; CpuAddr = 12'h300; CpuWData = 8'h77; settle();
    check("t6_scan_blocks", RamWe, 0);
    tick(); settle();                              // C13
    check("t6_grant1", RamWe, 1);
    tick(); tick(); settle();                      // C15 ACK
    check("t6_ack1", CpuAck, 1);
    check("t6_ack_ignored", RamWe, 0);
    tick(); settle();                              // C16 IDLE, scan slot
    check("t6_idle_scan", RamWe, 0);
    tick(); settle();                              // C17
    check("t6_grant2", RamWe, 1);
    tick(); tick(); settle();                      // C19 ACK
    check("t6_ack2", CpuAck, 1);
    CpuReq = 1'b0;
    check("t6_we_count", weCount - weBase, 2);

    // Out-of-range write and read at 4000, in-range write at 3999
    tick(); ScanActive = 1'b0; weBase = weCount;   // C20
    CpuReq = 1'b1; CpuWe = 1'b1; CpuAddr = 12'd4000; CpuWData = 8'hFF; settle();
    check("t4_oor_we", RamWe, 0);
    tick(); tick(); settle();                      // C22
    check("t4_oor_wack", CpuAck, 1);
    CpuReq = 1'b0;
    tick();                                        // C23
    CpuReq = 1'b1; CpuWe = 1'b0; settle();
    tick(); tick(); settle();                      // C25
    check("t4_oor_rack", CpuAck, 1);
    check("t4_oor_rdata", CpuRData, 8'h00);
    CpuReq = 1'b0;
    tick();                                        // C26
    CpuReq = 1'b1; CpuWe = 1'b1; CpuAddr = 12'd3999; CpuWData = 8'hEE; settle();
    check("t4_last_we", RamWe, 1);
    tick(); tick(); settle();                      // C28
    check("t4_last_ack", CpuAck, 1);
    CpuReq = 1'b0;
    check("t4_we_count", weCount - weBase, 1);

    // Cursor at (5,2) -> address 165, blink mode, 2 frames per half-period
    tick();                                        // C29
    CursorX = 7'd5; CursorY = 6'd2; CursorMode = 2'd2; ScanActive = 1'b1; ScanAddr = 12'd165;
    tick();                                        // C30 issue 165
    tick(); ScanAddr = 12'd164;                    // C31
    tick(); settle();                              // C32
    check("t5_char_cur", ScanChar, 8'h3C);
    check("t5_cur_hit", CursorEnable, 1);
    tick(); ScanAddr = 12'd165;                    // C33
    tick(); settle();                              // C34
    check("t5_char_other", ScanChar, 8'h11);
    check("t5_cur_miss", CursorEnable, 0);
    FrameStart = 1'b1;
    tick(); FrameStart = 1'b0;                     // C35
    tick(); settle();                              // C36
    check("t5_vis_after1", CursorEnable, 1);
    FrameStart = 1'b1;
    tick(); FrameStart = 1'b0;                     // C37
    tick(); settle();                              // C38
    check("t5_blink_off", CursorEnable, 0);
    check("t5_char_off", ScanChar, 8'h3C);
    FrameStart = 1'b1;
    tick(); FrameStart = 1'b0;                     // C39
    tick(); FrameStart = 1'b1;                     // C40
    tick(); FrameStart = 1'b0;                     // C41
    tick(); settle();                              // C42
    check("t5_blink_on", CursorEnable, 1);
    CursorMode = 2'd3;
    tick(); tick(); settle();                      // C44
    check("t5_mode_reserved", CursorEnable, 0);
    CursorMode = 2'd1;
    tick(); tick(); settle();                      // C46
    check("t5_mode_solid", CursorEnable, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
